instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 4-bit unicycle MIPS: program counter, instruction ROM,
// next-PC selection, halt latching, single-step debug and a committed-
// instruction counter.
//
// ROM contents come from the ROM_IMAGE parameter; word i sits at
// ROM_IMAGE[i*INSTR_W +: INSTR_W]. The image is fixed at elaboration.
//
// Ports:
//   Clock, Reset         clock, synchronous active-high reset
//   PCWrite              1 = commit next PC, 0 = halt
//   Jump, Branch, Zero   next-PC select from controller / ALU
//   StepMode, StepReq    single-step debug; a StepReq rising edge allows one commit
//   PC                   current program counter (registered)
//   Instr, OPCode        ROM[PC] and its top 3 bits (combinational)
//   PCPlus1              PC + 1 modulo 2^PC_W
//   Halted               set once the core has halted
//   InstrCount           saturating count of committed instructions
module instr_fetch_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 8,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned CNT_W   = 16,
  parameter logic [DEPTH*INSTR_W-1:0] ROM_IMAGE = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               PCWrite,
  input  logic               Jump,
  input  logic               Branch,
  input  logic               Zero,
  input  logic               StepMode,
  input  logic               StepReq,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] Instr,
  output logic [2:0]         OPCode,
  output logic [PC_W-1:0]    PCPlus1,
  output logic               Halted,
  output logic [CNT_W-1:0]   InstrCount
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halted_q, halted_d;
  logic               step_req_q;

  logic [INSTR_W-1:0] instr_c;
  logic [AW-1:0]      rom_idx;
  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    jump_tgt;
  logic [PC_W-1:0]    br_off;
  logic [PC_W-1:0]    next_pc;
  logic               step_pulse;
  logic               commit;

  // ROM read; fetches past the image return the halt opcode.
  assign rom_idx = pc_q[AW-1:0];

  always_comb begin
    instr_c = {3'b111, (INSTR_W-3)'(0)};
    if (32'(pc_q) < DEPTH) begin
      instr_c = ROM_IMAGE[32'(rom_idx)*INSTR_W +: INSTR_W];
    end
  end

  assign pc_plus1 = pc_q + PC_W'(1);

  // Jump keeps the PC bits above the 5-bit target field.
  if (PC_W > 5) begin : g_jump_wide
    assign jump_tgt = {pc_q[PC_W-1:5], instr_c[4:0]};
  end else begin : g_jump_narrow
    assign jump_tgt = instr_c[PC_W-1:0];
  end

  // 2-bit signed branch displacement (-2..+1) relative to PC+1.
  assign br_off = PC_W'($signed(instr_c[1:0]));

  always_comb begin
    next_pc = pc_plus1;
    if (Jump) begin
      next_pc = jump_tgt;
    end else if (Branch && Zero) begin
      next_pc = pc_plus1 + br_off;
    end
  end

  assign step_pulse = StepReq & ~step_req_q;
  assign commit     = (state_q == ST_RUN) & PCWrite & (~StepMode | step_pulse);

  // Next-state: halt on PCWrite=0 even while waiting for a step.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!PCWrite) begin
          state_d = ST_HALTED;
        end else if (commit) begin
          pc_d = next_pc;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
      step_req_q <= StepReq;
    end
  end

  assign PC         = pc_q;
  assign Instr      = instr_c;
  assign OPCode     = instr_c[INSTR_W-1 -: 3];
  assign PCPlus1    = pc_plus1;
  assign Halted     = halted_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: an 8-bit-PC instance (A) and a
// 5-bit-PC instance with a 3-bit counter (B) share one stimulus stream.
module tb_instr_fetch_unit;

  function automatic logic [255:0] mk_rom(input bit alt);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = 8'h20;
    if (!alt) begin
      r[3*8 +: 8]  = 8'hE0;
      r[5*8 +: 8]  = 8'hD4;
      r[10*8 +: 8] = 8'h02;
    end else begin
      r[10*8 +: 8] = 8'h01;
    end
    return r;
  endfunction

  localparam logic [255:0] ROM_A = mk_rom(1'b0);
  localparam logic [255:0] ROM_B = mk_rom(1'b1);

  logic Clock = 1'b0;
  logic Reset, PCWrite, Jump, Branch, Zero, StepMode, StepReq;

  logic [7:0]  pc_a, instr_a, pcp1_a;
  logic [2:0]  op_a;
  logic        halted_a;
  logic [15:0] cnt_a;

  logic [4:0]  pc_b, pcp1_b;
  logic [7:0]  instr_b;
  logic [2:0]  op_b;
  logic        halted_b;
  logic [2:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  instr_fetch_unit #(
    .PC_W(8), .INSTR_W(8), .DEPTH(32), .CNT_W(16), .ROM_IMAGE(ROM_A)
  ) u_dut_a (
    .Clock(Clock), .Reset(Reset), .PCWrite(PCWrite), .Jump(Jump),
    .Branch(Branch), .Zero(Zero), .StepMode(StepMode), .StepReq(StepReq),
    .PC(pc_a), .Instr(instr_a), .OPCode(op_a), .PCPlus1(pcp1_a),
    .Halted(halted_a), .InstrCount(cnt_a)
  );

  instr_fetch_unit #(
    .PC_W(5), .INSTR_W(8), .DEPTH(32), .CNT_W(3), .ROM_IMAGE(ROM_B)
  ) u_dut_b (
    .Clock(Clock), .Reset(Reset), .PCWrite(PCWrite), .Jump(Jump),
    .Branch(Branch), .Zero(Zero), .StepMode(StepMode), .StepReq(StepReq),
    .PC(pc_b), .Instr(instr_b), .OPCode(op_b), .PCPlus1(pcp1_b),
    .Halted(halted_b), .InstrCount(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic set_ctl(input logic pcw, input logic j, input logic b, input logic z);
    PCWrite = pcw;
    Jump    = j;
    Branch  = b;
    Zero    = z;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    StepMode = 1'b0;
    StepReq  = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    StepMode = 1'b0;
    StepReq  = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_pc",     32'(pc_a),     0);
    check_eq("rst_halted", 32'(halted_a), 0);
    check_eq("rst_cnt",    32'(cnt_a),    0);
    check_eq("rst_instr",  32'(instr_a),  'h20);
    check_eq("rst_op",     32'(op_a),     1);
    check_eq("rst_pcp1",   32'(pcp1_a),   1);

    // Sequential fetch 0..3, then halt at 3
    tick(); check_eq("seq_pc1", 32'(pc_a), 1);
    tick(); check_eq("seq_pc2", 32'(pc_a), 2);
    tick(); check_eq("seq_pc3", 32'(pc_a), 3);
    check_eq("seq_instr3", 32'(instr_a), 'hE0);
    check_eq("seq_op3",    32'(op_a),    7);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("halt_flag", 32'(halted_a), 1);
    check_eq("halt_pc",   32'(pc_a),     3);
    check_eq("halt_cnt",  32'(cnt_a),    3);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick(2);
    check_eq("halt_frozen_pc",  32'(pc_a),     3);
    check_eq("halt_frozen_cnt", 32'(cnt_a),    3);
    check_eq("halt_sticky",     32'(halted_a), 1);

    // Reset while halted, normal fetch resumes
    do_reset();
    check_eq("rsth_pc",     32'(pc_a),     0);
    check_eq("rsth_halted", 32'(halted_a), 0);
    check_eq("rsth_cnt",    32'(cnt_a),    0);
    tick(5);
    check_eq("jmp_pc5",    32'(pc_a),    5);
    check_eq("jmp_instr5", 32'(instr_a), 'hD4);
    check_eq("jmp_op5",    32'(op_a),    6);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("jmp_pc",  32'(pc_a),  'h14);
    check_eq("jmp_cnt", 32'(cnt_a), 6);

    // Jump wins over a taken branch
    do_reset();
    tick(5);
    set_ctl(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check_eq("jmp_over_br", 32'(pc_a), 'h14);

    // Branch: offset -2 taken, not taken
    do_reset();
    tick(10);
    check_eq("br_pc10", 32'(pc_a), 10);
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("br_taken_neg", 32'(pc_a), 9);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("br_back10", 32'(pc_a), 10);
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("br_not_taken", 32'(pc_a),  11);
    check_eq("br_cnt",       32'(cnt_a), 13);

    // Single-step mode
    do_reset();
    tick(2);
    StepMode = 1'b1;
    StepReq  = 1'b1;
    tick();
    check_eq("step_first", 32'(pc_a), 3);
    tick(4);
    check_eq("step_held_pc",  32'(pc_a),  3);
    check_eq("step_held_cnt", 32'(cnt_a), 3);
    StepReq = 1'b0; tick();
    StepReq = 1'b1; tick();
    check_eq("step_pc4", 32'(pc_a), 4);
    StepReq = 1'b0; tick();
    StepReq = 1'b1; tick();
    check_eq("step_pc5",  32'(pc_a),  5);
    check_eq("step_cnt5", 32'(cnt_a), 5);

    // Reset mid-step, StepReq still high
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_eq("rsts_pc",     32'(pc_a),     0);
    check_eq("rsts_halted", 32'(halted_a), 0);
    check_eq("rsts_cnt",    32'(cnt_a),    0);
    // Edge register was cleared, so a held StepReq counts as a new edge
    tick();
    check_eq("rsts_step_pc", 32'(pc_a), 1);
    // Halt while stepping needs no step edge
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("step_halt_flag", 32'(halted_a), 1);
    check_eq("step_halt_pc",   32'(pc_a),     1);
    check_eq("step_halt_cnt",  32'(cnt_a),    1);

    // Past the end of the ROM with an 8-bit PC
    do_reset();
    tick(31);
    check_eq("end_pc31",    32'(pc_a),    31);
    check_eq("end_instr31", 32'(instr_a), 'h20);
    tick();
    check_eq("oor_pc",    32'(pc_a),    32);
    check_eq("oor_instr", 32'(instr_a), 'hE0);
    check_eq("oor_op",    32'(op_a),    7);
    check_eq("oor_pcp1",  32'(pcp1_a),  33);

    // 5-bit PC instance: counter saturation, +1 branch, wrap
    do_reset();
    check_eq("b_rst_pc", 32'(pc_b), 0);
    tick(10);
    check_eq("b_pc10",    32'(pc_b),    10);
    check_eq("b_instr10", 32'(instr_b), 'h01);
    check_eq("b_cnt_sat", 32'(cnt_b),   7);
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("b_br_pos", 32'(pc_b), 12);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    tick(19);
    check_eq("b_pc31",   32'(pc_b),   31);
    check_eq("b_pcp1",   32'(pcp1_b), 0);
    tick();
    check_eq("b_wrap",    32'(pc_b),     0);
    check_eq("b_cnt",     32'(cnt_b),    7);
    check_eq("b_running", 32'(halted_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
